// File: rtl/vga_box_renderer.sv
// vga_box_renderer: pixel generator downstream of the VGA timing controller.
// Draws a solid background, a 1-pixel screen-edge frame and a square box that
// bounces off the screen edges once per frame. Two-stage output pipeline keeps
// RGB and the re-timed syncs mutually aligned, two cycles behind the inputs.
module vga_box_renderer #(
   parameter int unsigned H_ORG    = 297,
   parameter int unsigned V_ORG    = 36,
   parameter int unsigned H_ACT    = 1023,
   parameter int unsigned V_ACT    = 767,
   parameter int unsigned BOX      = 64,
   parameter int unsigned STEP     = 4,
   parameter int unsigned BOX_X0   = 0,
   parameter int unsigned BOX_Y0   = 0,
   parameter logic [11:0] BOX_RGB  = 12'hF00,
   parameter logic [11:0] BG_RGB   = 12'h008,
   parameter logic [11:0] EDGE_RGB = 12'hFFF
) (
   input  logic        clk_65M,
   input  logic        clear_n,
   input  logic        run,
   input  logic [16:0] H_cnt,
   input  logic [16:0] V_cnt,
   input  logic        Vid_on,
   input  logic        H_sync,
   input  logic        V_sync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hs_out,
   output logic        vs_out,
   output logic [10:0] box_x,
   output logic [10:0] box_y
);

   localparam logic [1:0] StWait = 2'd0;
   localparam logic [1:0] StUpdX = 2'd1;
   localparam logic [1:0] StUpdY = 2'd2;

   // Screen coordinates, 17-bit subtraction truncated to 11 bits
   logic [10:0] x_c;
   logic [10:0] y_c;
   logic        tick_c;
   logic        in_box_c;
   logic        edge_c;

   // Motion state
   logic [1:0]  state_q, state_d;
   logic [10:0] box_x_q, box_x_d;
   logic [10:0] box_y_q, box_y_d;
   logic        dx_q, dx_d;
   logic        dy_q, dy_d;

   // Stage 1 registers
   logic        in_box_q;
   logic        edge_q;
   logic        vid1_q;
   logic        hs1_q;
   logic        vs1_q;

   // Stage 2 registers
   logic [11:0] rgb_q, rgb_d;
   logic        hs2_q;
   logic        vs2_q;

   // Coordinate generation and pixel classification compares
   always_comb begin
      logic [11:0] bx;
      logic [11:0] by;
      logic [11:0] px;
      logic [11:0] py;
      x_c      = 11'(H_cnt - 17'(H_ORG));
      y_c      = 11'(V_cnt - 17'(V_ORG));
      tick_c   = (H_cnt == 17'd0) && (V_cnt == 17'd0);
      // Widen to 12 bits so box_x + BOX cannot wrap
      bx       = {1'b0, box_x_q};
      by       = {1'b0, box_y_q};
      px       = {1'b0, x_c};
      py       = {1'b0, y_c};
      in_box_c = (px >= bx) && (px < bx + 12'(BOX)) &&
                 (py >= by) && (py < by + 12'(BOX));
      edge_c   = (x_c == 11'd0) || (x_c == 11'(H_ACT - 1)) ||
                 (y_c == 11'd0) || (y_c == 11'(V_ACT - 1));
   end

   // Stage 1: register compare results and pass-through controls
   always_ff @(posedge clk_65M or negedge clear_n) begin
      if (!clear_n) begin
         in_box_q <= 1'b0;
         edge_q   <= 1'b0;
         vid1_q   <= 1'b0;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
      end else begin
         in_box_q <= in_box_c;
         edge_q   <= edge_c;
         vid1_q   <= Vid_on;
         hs1_q    <= H_sync;
         vs1_q    <= V_sync;
      end
   end

   // Colour select: blanking beats edge beats box beats background
   always_comb begin
      rgb_d = BG_RGB;
      if (!vid1_q) begin
         rgb_d = 12'h000;
      end else if (edge_q) begin
         rgb_d = EDGE_RGB;
      end else if (in_box_q) begin
         rgb_d = BOX_RGB;
      end
   end

   // Stage 2: final RGB and re-timed syncs
   always_ff @(posedge clk_65M or negedge clear_n) begin
      if (!clear_n) begin
         rgb_q <= 12'h000;
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
      end else begin
         rgb_q <= rgb_d;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   // Motion FSM: one axis per cycle after the frame tick
   always_comb begin
      state_d = state_q;
      box_x_d = box_x_q;
      box_y_d = box_y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      case (state_q)
         StWait: begin
            if (tick_c && run) begin
               state_d = StUpdX;
            end
         end
         StUpdX: begin
            state_d = StUpdY;
            if (dx_q) begin
               if ({1'b0, box_x_q} + 12'(BOX + STEP) > 12'(H_ACT)) begin
                  box_x_d = 11'(H_ACT - BOX);
                  dx_d    = 1'b0;
               end else begin
                  box_x_d = box_x_q + 11'(STEP);
               end
            end else begin
               if (box_x_q < 11'(STEP)) begin
                  box_x_d = 11'd0;
                  dx_d    = 1'b1;
               end else begin
                  box_x_d = box_x_q - 11'(STEP);
               end
            end
         end
         StUpdY: begin
            state_d = StWait;
            if (dy_q) begin
               if ({1'b0, box_y_q} + 12'(BOX + STEP) > 12'(V_ACT)) begin
                  box_y_d = 11'(V_ACT - BOX);
                  dy_d    = 1'b0;
               end else begin
                  box_y_d = box_y_q + 11'(STEP);
               end
            end else begin
               if (box_y_q < 11'(STEP)) begin
                  box_y_d = 11'd0;
                  dy_d    = 1'b1;
               end else begin
                  box_y_d = box_y_q - 11'(STEP);
               end
            end
         end
         default: state_d = StWait;
      endcase
   end

   // Motion state registers
   always_ff @(posedge clk_65M or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= StWait;
         box_x_q <= 11'(BOX_X0);
         box_y_q <= 11'(BOX_Y0);
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         box_x_q <= box_x_d;
         box_y_q <= box_y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
      end
   end

   assign vga_r  = rgb_q[11:8];
   assign vga_g  = rgb_q[7:4];
   assign vga_b  = rgb_q[3:0];
   assign hs_out = hs2_q;
   assign vs_out = vs2_q;
   assign box_x  = box_x_q;
   assign box_y  = box_y_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: table-driven pixel classification plus directed
// sequences for latency, bounce, freeze and mid-frame reset. Three instances
// share stimulus: default start (0,0), right-edge start (955,0), corner (959,703).
module tb_vga_box_renderer;

   logic        clk = 1'b0;
   logic        clear_n;
   logic        run;
   logic [16:0] h_cnt;
   logic [16:0] v_cnt;
   logic        vid_on;
   logic        h_sync;
   logic        v_sync;

   logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
   logic        hs0, vs0, hs1, vs1, hs2, vs2;
   logic [10:0] bx0, by0, bx1, by1, bx2, by2;

   int checks   = 0;
   int failures = 0;

   always #8 clk = ~clk;

   vga_box_renderer dut (
      .clk_65M(clk), .clear_n(clear_n), .run(run), .H_cnt(h_cnt), .V_cnt(v_cnt),
      .Vid_on(vid_on), .H_sync(h_sync), .V_sync(v_sync),
      .vga_r(r0), .vga_g(g0), .vga_b(b0), .hs_out(hs0), .vs_out(vs0),
      .box_x(bx0), .box_y(by0)
   );

   vga_box_renderer #(.BOX_X0(955), .BOX_Y0(0)) dut_r (
      .clk_65M(clk), .clear_n(clear_n), .run(run), .H_cnt(h_cnt), .V_cnt(v_cnt),
      .Vid_on(vid_on), .H_sync(h_sync), .V_sync(v_sync),
      .vga_r(r1), .vga_g(g1), .vga_b(b1), .hs_out(hs1), .vs_out(vs1),
      .box_x(bx1), .box_y(by1)
   );

   vga_box_renderer #(.BOX_X0(959), .BOX_Y0(703)) dut_c (
      .clk_65M(clk), .clear_n(clear_n), .run(run), .H_cnt(h_cnt), .V_cnt(v_cnt),
      .Vid_on(vid_on), .H_sync(h_sync), .V_sync(v_sync),
      .vga_r(r2), .vga_g(g2), .vga_b(b2), .hs_out(hs2), .vs_out(vs2),
      .box_x(bx2), .box_y(by2)
   );

   typedef struct {
      string       name;
      logic [16:0] h;
      logic [16:0] v;
      logic        vid;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
      logic        ehs;
      logic        evs;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [16:0] h, input logic [16:0] v, input logic vid,
                        input logic hs, input logic vs);
      h_cnt  = h;
      v_cnt  = v;
      vid_on = vid;
      h_sync = hs;
      v_sync = vs;
   endtask

   // Advance n rising edges, land 1 time unit after the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame tick followed by enough idle blanking for both axis updates
   task automatic tick();
      drive(17'd0, 17'd0, 1'b0, 1'b1, 1'b1);
      cyc(1);
      drive(17'd5, 17'd0, 1'b0, 1'b1, 1'b1);
      cyc(4);
   endtask

   // Tick with cycle-exact checks of when each axis changes (default instance)
   task automatic timed_tick();
      drive(17'd0, 17'd0, 1'b0, 1'b1, 1'b1);
      cyc(1);
      drive(17'd5, 17'd0, 1'b0, 1'b1, 1'b1);
      chk("box_x_before_updx", int'(bx0), 0);
      cyc(1);
      chk("box_x_at_tick_plus2", int'(bx0), 4);
      chk("box_y_at_tick_plus2", int'(by0), 0);
      cyc(1);
      chk("box_y_at_tick_plus3", int'(by0), 4);
      cyc(2);
   endtask

   int exp_r_x[4] = '{959, 959, 955, 951};
   int exp_r_y[4] = '{4, 8, 12, 16};
   int exp_c_x[4] = '{959, 955, 951, 947};
   int exp_c_y[4] = '{703, 699, 695, 691};

   initial begin
      // name, H, V, vid, hs, vs, rgb, hs_out, vs_out
      vecs[0]  = '{"origin_edge",    17'd297,  17'd36,  1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
      vecs[1]  = '{"box_10_10",      17'd307,  17'd46,  1'b1, 1'b1, 1'b1, 12'hF00, 1'b1, 1'b1};
      vecs[2]  = '{"bg_100_10",      17'd397,  17'd46,  1'b1, 1'b1, 1'b1, 12'h008, 1'b1, 1'b1};
      vecs[3]  = '{"blank_10_10",    17'd307,  17'd46,  1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
      vecs[4]  = '{"edge_top_in_box",17'd307,  17'd36,  1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
      vecs[5]  = '{"edge_right",     17'd1319, 17'd336, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
      vecs[6]  = '{"bg_x1021",       17'd1318, 17'd336, 1'b1, 1'b1, 1'b1, 12'h008, 1'b1, 1'b1};
      vecs[7]  = '{"edge_bottom",    17'd797,  17'd802, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
      vecs[8]  = '{"bg_y765",        17'd797,  17'd801, 1'b1, 1'b1, 1'b1, 12'h008, 1'b1, 1'b1};
      vecs[9]  = '{"box_63_63",      17'd360,  17'd99,  1'b1, 1'b1, 1'b1, 12'hF00, 1'b1, 1'b1};
      vecs[10] = '{"bg_64_63",       17'd361,  17'd99,  1'b1, 1'b1, 1'b1, 12'h008, 1'b1, 1'b1};
      vecs[11] = '{"bg_63_64",       17'd360,  17'd100, 1'b1, 1'b1, 1'b1, 12'h008, 1'b1, 1'b1};
      vecs[12] = '{"hsync_low",      17'd100,  17'd10,  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1};
      vecs[13] = '{"vsync_low_box",  17'd320,  17'd60,  1'b1, 1'b1, 1'b0, 12'hF00, 1'b1, 1'b0};

      clear_n = 1'b0;
      run     = 1'b0;
      drive(17'd5, 17'd0, 1'b0, 1'b1, 1'b1);
      cyc(3);
      chk("reset_rgb", int'({r0, g0, b0}), 'h000);
      chk("reset_hs", int'(hs0), 1);
      chk("reset_vs", int'(vs0), 1);
      chk("reset_box_x", int'(bx0), 0);
      chk("reset_box_y", int'(by0), 0);
      chk("reset_box_x_r", int'(bx1), 955);
      chk("reset_box_y_c", int'(by2), 703);
      clear_n = 1'b1;
      cyc(1);

      // Pixel classification table, box at reset position (0,0)
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].h, vecs[i].v, vecs[i].vid, vecs[i].hs, vecs[i].vs);
         cyc(2);
         chk({vecs[i].name, "_rgb"}, int'({r0, g0, b0}), int'(vecs[i].rgb));
         chk({vecs[i].name, "_hs"}, int'(hs0), int'(vecs[i].ehs));
         chk({vecs[i].name, "_vs"}, int'(vs0), int'(vecs[i].evs));
      end

      // Latency: edge pixel must appear exactly two cycles later
      drive(17'd400, 17'd300, 1'b1, 1'b1, 1'b1);
      cyc(3);
      drive(17'd297, 17'd36, 1'b1, 1'b0, 1'b1);
      cyc(1);
      chk("lat_rgb_cycle1", int'({r0, g0, b0}), 'h008);
      chk("lat_hs_cycle1", int'(hs0), 1);
      drive(17'd400, 17'd300, 1'b1, 1'b1, 1'b1);
      cyc(1);
      chk("lat_rgb_cycle2", int'({r0, g0, b0}), 'hFFF);
      chk("lat_hs_cycle2", int'(hs0), 0);
      cyc(1);
      chk("lat_rgb_cycle3", int'({r0, g0, b0}), 'h008);
      chk("lat_hs_cycle3", int'(hs0), 1);

      // Bounce sequences with run = 1
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) timed_tick();
         else tick();
         chk($sformatf("move_def_x%0d", i), int'(bx0), 4 * (i + 1));
         chk($sformatf("move_def_y%0d", i), int'(by0), 4 * (i + 1));
         chk($sformatf("right_x%0d", i), int'(bx1), exp_r_x[i]);
         chk($sformatf("right_y%0d", i), int'(by1), exp_r_y[i]);
         chk($sformatf("corner_x%0d", i), int'(bx2), exp_c_x[i]);
         chk($sformatf("corner_y%0d", i), int'(by2), exp_c_y[i]);
      end

      // Freeze across three ticks, then resume in the held direction
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("freeze_r_x%0d", i), int'(bx1), 951);
         chk($sformatf("freeze_c_y%0d", i), int'(by2), 691);
      end
      run = 1'b1;
      tick();
      chk("resume_r_x", int'(bx1), 947);
      chk("resume_r_y", int'(by1), 20);
      chk("resume_c_x", int'(bx2), 943);
      chk("resume_c_y", int'(by2), 687);

      // Box now at (20,20) in the default instance
      drive(17'd318, 17'd56, 1'b1, 1'b1, 1'b1);
      cyc(2);
      chk("moved_box_pixel", int'({r0, g0, b0}), 'hF00);
      drive(17'd314, 17'd56, 1'b1, 1'b1, 1'b1);
      cyc(2);
      chk("moved_left_of_box", int'({r0, g0, b0}), 'h008);

      // Mid-frame reset: outputs drop immediately, recover two cycles after release
      drive(17'd297, 17'd36, 1'b1, 1'b0, 1'b0);
      cyc(2);
      chk("pre_reset_rgb", int'({r0, g0, b0}), 'hFFF);
      clear_n = 1'b0;
      #1;
      chk("midreset_rgb", int'({r0, g0, b0}), 'h000);
      chk("midreset_hs", int'(hs0), 1);
      chk("midreset_vs", int'(vs0), 1);
      chk("midreset_box_x", int'(bx0), 0);
      chk("midreset_box_y_r", int'(by1), 0);
      cyc(2);
      chk("held_reset_rgb", int'({r0, g0, b0}), 'h000);
      clear_n = 1'b1;
      cyc(1);
      chk("post_release_c1", int'({r0, g0, b0}), 'h000);
      cyc(1);
      chk("post_release_c2", int'({r0, g0, b0}), 'hFFF);
      chk("post_release_hs", int'(hs0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
